// File: rtl/monolith_axis_state_tx.sv
// monolith_axis_state_tx: egress serializer for the Monolith permutation core.
// Captures a full NUM_WORDS-word state in one cycle and streams it out as an
// AXI4-Stream master, word 0 first, TLAST on the final word. The Mersenne-31
// value p = 2^31-1 can be folded to 0 so the host only sees canonical values.
module monolith_axis_state_tx #(
   parameter int NUM_WORDS    = 16,
   parameter int WORD_W       = 31,
   parameter int AXIS_W       = 32,
   parameter bit CANONICALIZE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] state_in [0:NUM_WORDS-1],
   input  logic              state_valid,
   output logic              state_ready,
   output logic [AXIS_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic [15:0]       frames_sent
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_inc_s;
   logic              last_s;
   logic              capture_s;
   logic              advance_s;
   logic              finish_s;
   logic              ready_s;
   logic [WORD_W-1:0] buf_r [0:NUM_WORDS-1];
   logic [AXIS_W-1:0] tdata_r;
   logic              tvalid_r;
   logic              tlast_r;
   logic              busy_r;
   logic [15:0]       frames_r;

   // Fold the non-canonical encoding of zero (all ones) back to zero.
   function automatic logic [WORD_W-1:0] canon(input logic [WORD_W-1:0] x);
      if (CANONICALIZE && (x == {WORD_W{1'b1}})) begin
         canon = {WORD_W{1'b0}};
      end else begin
         canon = x;
      end
   endfunction

   assign idx_inc_s = idx_r + IDX_W'(1);
   assign last_s    = (idx_r == LAST_IDX);

   // Next-state decode: capture in IDLE or on an accepted last beat, else step the index.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      advance_s   = 1'b0;
      finish_s    = 1'b0;
      ready_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (state_valid) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (m_axis_tready) begin
               if (last_s) begin
                  // Accepting the last beat frees the buffer this same cycle,
                  // which is what allows gap-free back-to-back frames.
                  ready_s  = 1'b1;
                  finish_s = 1'b1;
                  if (state_valid) begin
                     capture_s   = 1'b1;
                     state_nxt_s = ST_SEND;
                  end else begin
                     state_nxt_s = ST_IDLE;
                  end
               end else begin
                  advance_s   = 1'b1;
                  state_nxt_s = ST_SEND;
               end
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Beat index and registered stream outputs; the word for the next beat is
   // looked up one cycle early so tdata comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_r    <= {IDX_W{1'b0}};
         tdata_r  <= {AXIS_W{1'b0}};
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else if (capture_s) begin
         idx_r    <= {IDX_W{1'b0}};
         tdata_r  <= AXIS_W'(canon(state_in[0]));
         tvalid_r <= 1'b1;
         tlast_r  <= (LAST_IDX == {IDX_W{1'b0}});
         busy_r   <= 1'b1;
      end else if (advance_s) begin
         idx_r    <= idx_inc_s;
         tdata_r  <= AXIS_W'(canon(buf_r[idx_inc_s]));
         tlast_r  <= (idx_inc_s == LAST_IDX);
      end else if (finish_s) begin
         idx_r    <= {IDX_W{1'b0}};
         tdata_r  <= {AXIS_W{1'b0}};
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         busy_r   <= 1'b0;
      end
   end

   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frames_r <= 16'd0;
      end else if (finish_s) begin
         frames_r <= frames_r + 16'd1;
      end
   end

   // Capture buffer; contents are don't-care after reset so it has no reset.
   always_ff @(posedge clk) begin
      if (capture_s) begin
         buf_r <= state_in;
      end
   end

   assign state_ready   = ready_s;
   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign busy          = busy_r;
   assign frames_sent   = frames_r;

endmodule

// File: tb/tb_monolith_axis_state_tx.sv
// Bench for monolith_axis_state_tx: a per-cycle scoreboard (queue of pending
// beats) runs throughout, plus table-driven and hand-written sequences.
module tb_monolith_axis_state_tx;

   localparam int NW = 16;
   localparam int WW = 31;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [WW-1:0] state_in [0:NW-1];
   logic          state_valid = 1'b0;
   logic          m_axis_tready = 1'b0;
   logic          state_ready, m_axis_tvalid, m_axis_tlast, busy;
   logic [AW-1:0] m_axis_tdata;
   logic [15:0]   frames_sent;
   logic          raw_ready, raw_tvalid, raw_tlast, raw_busy;
   logic [AW-1:0] raw_tdata;
   logic [15:0]   raw_frames;

   int n_cmp = 0;
   int n_err = 0;

   monolith_axis_state_tx #(.NUM_WORDS(NW), .WORD_W(WW), .AXIS_W(AW), .CANONICALIZE(1'b1)) u_dut (
      .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
      .state_ready(state_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
      .frames_sent(frames_sent));

   monolith_axis_state_tx #(.NUM_WORDS(NW), .WORD_W(WW), .AXIS_W(AW), .CANONICALIZE(1'b0)) u_raw (
      .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
      .state_ready(raw_ready), .m_axis_tdata(raw_tdata), .m_axis_tvalid(raw_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(raw_tlast), .busy(raw_busy),
      .frames_sent(raw_frames));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: queue of beats still owed ----------------
   typedef struct packed {
      logic [31:0] c;
      logic [31:0] r;
      logic        last;
   } beat_t;

   beat_t q[$];
   int    m_frames = 0;

   function automatic logic [31:0] mcanon(input logic [WW-1:0] x);
      logic [31:0] v;
      v = {1'b0, x};
      if (v == 32'h7FFF_FFFF) v = 32'd0;
      return v;
   endfunction

   always @(negedge clk) begin
      logic acc;
      logic owed;
      beat_t b;
      if (!reset) begin
         check("rst_tvalid", m_axis_tvalid, 1'b0);
         check("rst_tlast", m_axis_tlast, 1'b0);
         check("rst_tdata", m_axis_tdata, 32'd0);
         check("rst_busy", busy, 1'b0);
         check("rst_frames", frames_sent, 16'd0);
         check("rst_raw_tvalid", raw_tvalid, 1'b0);
         q.delete();
         m_frames = 0;
      end else begin
         owed = (q.size() != 0);
         acc  = (q.size() == 0) || (q.size() == 1 && m_axis_tready);
         check("sb_tvalid", m_axis_tvalid, owed);
         check("sb_busy", busy, owed);
         check("sb_raw_tvalid", raw_tvalid, owed);
         check("sb_ready", state_ready, acc);
         check("sb_raw_ready", raw_ready, acc);
         check("sb_frames", frames_sent, m_frames[15:0]);
         if (owed) begin
            check("sb_tdata", m_axis_tdata, q[0].c);
            check("sb_raw_tdata", raw_tdata, q[0].r);
            check("sb_tlast", m_axis_tlast, q[0].last);
            if (m_axis_tready) begin
               if (q[0].last) m_frames = (m_frames + 1) % 65536;
               void'(q.pop_front());
            end
         end
         if (acc && state_valid) begin
            for (int i = 0; i < NW; i++) begin
               b.c = mcanon(state_in[i]);
               b.r = {1'b0, state_in[i]};
               b.last = (i == NW - 1);
               q.push_back(b);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp(input logic [WW-1:0] base);
      for (int i = 0; i < NW; i++) state_in[i] = base + WW'(i);
   endtask

   task automatic drain(input string nm);
      int c;
      c = 0;
      while (m_axis_tvalid && c < 200) begin
         step();
         c++;
      end
      check({nm, "_drain_timeout"}, m_axis_tvalid, 1'b0);
   endtask

   typedef struct {
      logic [WW-1:0] word;
      logic [31:0]   exp_c;
      logic [31:0]   exp_r;
   } vec_t;

   vec_t tbl [NW];

   initial begin
      logic [3:0]  pat;
      logic [31:0] got [NW];
      logic [31:0] prev_d;
      logic        prev_l, prev_stall, cap_now;
      int          nb, first, lastc, pulses, c;
      logic [WW-1:0] w;

      // canonicalization vectors: word, expected canonical, expected raw
      for (int i = 0; i < NW; i++) tbl[i] = '{31'd0, 32'd0, 32'd0};
      tbl[0]  = '{31'h0000_0001, 32'h0000_0001, 32'h0000_0001};
      tbl[3]  = '{31'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
      tbl[4]  = '{31'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h7FFF_FFFE};
      tbl[9]  = '{31'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      tbl[15] = '{31'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};

      load_ramp(31'd0);
      // reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check("reset_ready", state_ready, 1'b1);
      check("reset_tvalid", m_axis_tvalid, 1'b0);

      // single frame, tready = 1
      load_ramp(31'd1);
      m_axis_tready = 1'b1;
      state_valid = 1'b1;
      check("single_pre_tvalid", m_axis_tvalid, 1'b0);
      step();
      state_valid = 1'b0;
      for (int b = 0; b < NW; b++) begin
         check("single_tvalid", m_axis_tvalid, 1'b1);
         check("single_tdata", m_axis_tdata, 32'(b + 1));
         check("single_tlast", m_axis_tlast, (b == NW - 1));
         step();
      end
      check("single_after_tvalid", m_axis_tvalid, 1'b0);
      check("single_frames", frames_sent, 16'd1);

      // canonicalization table, both instances
      for (int i = 0; i < NW; i++) state_in[i] = tbl[i].word;
      state_valid = 1'b1;
      step();
      state_valid = 1'b0;
      for (int b = 0; b < NW; b++) begin
         check("canon_tdata", m_axis_tdata, tbl[b].exp_c);
         check("raw_tdata", raw_tdata, tbl[b].exp_r);
         check("canon_tlast", m_axis_tlast, (b == NW - 1));
         step();
      end

      // backpressure 1,0,0,1
      load_ramp(31'h4000_0000);
      pat = 4'b1001;
      state_valid = 1'b1;
      step();
      state_valid = 1'b0;
      nb = 0;
      prev_stall = 1'b0;
      prev_d = 32'd0;
      prev_l = 1'b0;
      c = 0;
      while (nb < NW && c < 200) begin
         m_axis_tready = pat[c % 4];
         #1;
         if (prev_stall) begin
            check("bp_stall_tdata", m_axis_tdata, prev_d);
            check("bp_stall_tlast", m_axis_tlast, prev_l);
         end
         check("bp_busy", busy, 1'b1);
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_d = m_axis_tdata;
         prev_l = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            got[nb] = m_axis_tdata;
            nb++;
         end
         step();
         c++;
      end
      check("bp_count", nb, NW);
      for (int i = 0; i < NW; i++) check("bp_order", got[i], 32'h4000_0000 + 32'(i));
      check("bp_done_busy", busy, 1'b0);
      m_axis_tready = 1'b1;

      // back-to-back frames A (0x11) and B (0x22)
      for (int i = 0; i < NW; i++) state_in[i] = 31'h11;
      state_valid = 1'b1;
      step();
      for (int i = 0; i < NW; i++) state_in[i] = 31'h22;
      nb = 0; first = -1; lastc = -1; pulses = 0; c = 0;
      while (!(nb > 0 && !m_axis_tvalid) && c < 80) begin
         if (m_axis_tvalid) begin
            check("b2b_tdata", m_axis_tdata, (nb < NW) ? 32'h11 : 32'h22);
            check("b2b_tlast", m_axis_tlast, (nb == NW - 1) || (nb == 2 * NW - 1));
            if (first < 0) first = c;
            lastc = c;
            nb++;
            if (state_ready) pulses++;
         end
         cap_now = state_valid && state_ready;
         step();
         if (cap_now) state_valid = 1'b0;
         c++;
      end
      state_valid = 1'b0;
      check("b2b_beats", nb, 2 * NW);
      check("b2b_no_gap", lastc - first, 2 * NW - 1);
      check("b2b_ready_pulses", pulses, 2);
      check("b2b_frames", frames_sent, 16'd5);

      // ignore while busy
      load_ramp(31'h100);
      state_valid = 1'b1;
      step();
      state_valid = 1'b0;
      for (int b = 0; b < NW; b++) begin
         if (b == 5) begin
            for (int i = 0; i < NW; i++) state_in[i] = 31'h5A5;
            state_valid = 1'b1;
            #1;
            check("ign_ready", state_ready, 1'b0);
         end
         check("ign_tdata", m_axis_tdata, 32'h100 + 32'(b));
         step();
         state_valid = 1'b0;
      end
      check("ign_after_tvalid", m_axis_tvalid, 1'b0);
      check("ign_frames", frames_sent, 16'd6);

      // async reset mid-frame
      load_ramp(31'h200);
      state_valid = 1'b1;
      step();
      state_valid = 1'b0;
      repeat (8) step();
      check("ar_beat8", m_axis_tdata, 32'h208);
      #2 reset = 1'b0;
      #1;
      check("ar_tvalid", m_axis_tvalid, 1'b0);
      check("ar_tlast", m_axis_tlast, 1'b0);
      check("ar_busy", busy, 1'b0);
      check("ar_frames", frames_sent, 16'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      check("ar_idle_ready", state_ready, 1'b1);
      check("ar_idle_tvalid", m_axis_tvalid, 1'b0);
      load_ramp(31'h300);
      state_valid = 1'b1;
      step();
      state_valid = 1'b0;
      check("ar_restart_word0", m_axis_tdata, 32'h300);
      drain("ar");
      check("ar_restart_frames", frames_sent, 16'd1);

      // randomized traffic against the scoreboard
      for (int k = 0; k < 800; k++) begin
         m_axis_tready = ($urandom_range(0, 9) < 7);
         if (!state_valid && $urandom_range(0, 3) == 0) begin
            for (int i = 0; i < NW; i++) begin
               w = WW'($urandom());
               if ($urandom_range(0, 7) == 0) w = 31'h7FFF_FFFF;
               state_in[i] = w;
            end
            state_valid = 1'b1;
         end
         #1;
         cap_now = state_valid && state_ready;
         step();
         if (cap_now) state_valid = 1'b0;
      end
      state_valid = 1'b0;
      m_axis_tready = 1'b1;
      drain("rand");
      step();
      check("rand_frames_model", frames_sent, m_frames[15:0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
